// File: rtl/bcd_pkg.sv
// Shared types and sizing helpers for the product-to-BCD conversion block.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} conv_state_t;

  localparam int IN_W_DEF   = 16;
  localparam int DIGITS_DEF = 5;

  function automatic int count_width(input int in_w);
    return (in_w > 1) ? $clog2(in_w) : 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to any BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  always_comb adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: multiplier product -> sign + packed BCD digits.
// Define SIGNED_INPUT_EN to treat the product as two's complement; otherwise it is unsigned.
module product_bcd_converter
  import bcd_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       product,
  output logic                  busy,
  output logic                  done,
  output logic                  sign_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_out
);

  localparam int                CNT_W     = count_width(IN_W);
  localparam int                BCD_W     = 4 * DIGITS;
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(IN_W - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  conv_state_t      state, state_next;
  logic [IN_W-1:0]  mag, mag_load;
  logic             sign_lat, sign_load;
  logic [BCD_W-1:0] scratch, scratch_adj, scratch_shift;
  logic [CNT_W-1:0] count;

  // Bit i marks digit i blank when it and every higher digit are zero; the units digit always shows.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] bcd);
    logic [DIGITS-1:0] m;
    logic              all_zero;
    all_zero = 1'b1;
    m        = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero & (bcd[4*i +: 4] == 4'd0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

`ifdef SIGNED_INPUT_EN
  assign sign_load = product[IN_W-1];
  assign mag_load  = sign_load ? (~product + IN_W'(1)) : product;
`else
  assign sign_load = 1'b0;
  assign mag_load  = product;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (scratch[4*g +: 4]),
      .adj   (scratch_adj[4*g +: 4])
    );
  end

  assign scratch_shift = {scratch_adj[BCD_W-2:0], mag[IN_W-1]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: begin
        busy = 1'b1;
        if (count == LAST_STEP) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load on start, one add-3/shift step per CONVERT cycle, publish on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag       <= '0;
      scratch   <= '0;
      count     <= '0;
      sign_lat  <= 1'b0;
      sign_out  <= 1'b0;
      bcd_out   <= '0;
      blank_out <= BLANK_RST;
    end else begin
      case (state)
        IDLE: if (start) begin
          mag      <= mag_load;
          scratch  <= '0;
          count    <= '0;
          sign_lat <= sign_load;
        end
        CONVERT: begin
          scratch <= scratch_shift;
          mag     <= {mag[IN_W-2:0], 1'b0};
          count   <= count + CNT_W'(1);
          if (count == LAST_STEP) begin
            sign_out  <= sign_lat & (scratch_shift != '0);
            bcd_out   <= scratch_shift;
            blank_out <= blank_mask(scratch_shift);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter against an arithmetic decimal model.
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] product;
  logic        busy, done, sign_out;
  logic [19:0] bcd_out;
  logic [4:0]  blank_out;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  product_bcd_converter #(.IN_W(16), .DIGITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .product   (product),
    .busy      (busy),
    .done      (done),
    .sign_out  (sign_out),
    .bcd_out   (bcd_out),
    .blank_out (blank_out)
  );

  // Decimal digits by repeated division; blank bit i set when the magnitude is below 10^i.
  function automatic void model(input logic [15:0] p, output logic s,
                                output logic [19:0] b, output logic [4:0] bl);
    int m, v, pw;
    s = 1'b0;
    m = int'(p);
`ifdef SIGNED_INPUT_EN
    if (p >= 16'h8000) begin
      s = 1'b1;
      m = 65536 - int'(p);
    end
`endif
    v = m;
    b = '0;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    pw = 1;
    bl = '0;
    for (int i = 1; i < 5; i++) begin
      pw    = pw * 10;
      bl[i] = (m < pw);
    end
  endfunction

  // Called at a negedge; returns at the negedge following the start sample (cycle 1).
  task automatic start_conv(input logic [15:0] p);
    start   = 1'b1;
    product = p;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    product = 16'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int busy_cnt, output bit got);
    cyc      = 1;
    busy_cnt = 0;
    got      = 1'b0;
    while (cyc <= 40) begin
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b0;
    product = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (sign_out !== 1'b0) begin fails++; $display("FAIL reset_sign: got %b expected 0", sign_out); end
    checks++; if (bcd_out !== 20'h00000) begin fails++; $display("FAIL reset_bcd: got %h expected 00000", bcd_out); end
    checks++; if (blank_out !== 5'b11110) begin fails++; $display("FAIL reset_blank: got %b expected 11110", blank_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known_values();
    logic [15:0] vals [6] = '{16'h0000, 16'h3000, 16'hFFFF, 16'h8000, 16'h0064, 16'h0001};
    logic s; logic [19:0] b; logic [4:0] bl;
    int cyc, bc; bit got;
    foreach (vals[i]) begin
      model(vals[i], s, b, bl);
      start_conv(vals[i]);
      wait_done(cyc, bc, got);
      checks++; if (!got || cyc != 17) begin fails++; $display("FAIL known_latency p=%h: got %0d (done=%b) expected 17", vals[i], cyc, got); end
      checks++; if (bc != 17) begin fails++; $display("FAIL known_busy p=%h: got %0d busy cycles expected 17", vals[i], bc); end
      checks++; if (sign_out !== s) begin fails++; $display("FAIL known_sign p=%h: got %b expected %b", vals[i], sign_out, s); end
      checks++; if (bcd_out !== b) begin fails++; $display("FAIL known_bcd p=%h: got %h expected %h", vals[i], bcd_out, b); end
      checks++; if (blank_out !== bl) begin fails++; $display("FAIL known_blank p=%h: got %b expected %b", vals[i], blank_out, bl); end
      if (vals[i] == 16'h3000) begin
        checks++; if (bcd_out !== 20'h12288) begin fails++; $display("FAIL known_12288: got %h expected 12288", bcd_out); end
      end
      if (vals[i] == 16'h8000) begin
        checks++; if (bcd_out !== 20'h32768) begin fails++; $display("FAIL known_32768: got %h expected 32768", bcd_out); end
      end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL known_pulse p=%h: got done=%b busy=%b expected 0 0", vals[i], done, busy); end
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bc; bit got;
    start_conv(16'h0001);
    repeat (4) @(negedge clk);
    start   = 1'b1;
    product = 16'h0002;
    @(negedge clk);
    start   = 1'b0;
    wait_done(cyc, bc, got);
    checks++; if (!got) begin fails++; $display("FAIL ignore_done: got no done expected one pulse"); end
    checks++; if (bcd_out !== 20'h00001) begin fails++; $display("FAIL ignore_bcd: got %h expected 00001", bcd_out); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL ignore_second_pulse: got %b expected 0", done); end
    start_conv(16'h0002);
    wait_done(cyc, bc, got);
    checks++; if (!got || cyc != 17) begin fails++; $display("FAIL ignore_restart_latency: got %0d (done=%b) expected 17", cyc, got); end
    checks++; if (bcd_out !== 20'h00002) begin fails++; $display("FAIL ignore_restart_bcd: got %h expected 00002", bcd_out); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, bc; bit got, seen;
    start_conv(16'h3000);
    wait_done(cyc, bc, got);
    checks++; if (!got || bcd_out !== 20'h12288) begin fails++; $display("FAIL midrst_pre: got %h (done=%b) expected 12288", bcd_out, got); end
    @(negedge clk);
    start_conv(16'h0064);
    seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (seen || done !== 1'b0) begin fails++; $display("FAIL midrst_done: got done seen=%b now=%b expected 0", seen, done); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (sign_out !== 1'b0) begin fails++; $display("FAIL midrst_sign: got %b expected 0", sign_out); end
    checks++; if (bcd_out !== 20'h00000) begin fails++; $display("FAIL midrst_bcd: got %h expected 00000", bcd_out); end
    checks++; if (blank_out !== 5'b11110) begin fails++; $display("FAIL midrst_blank: got %b expected 11110", blank_out); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrst_idle: got busy=%b done=%b expected 0 0", busy, done); end
    start_conv(16'h0064);
    wait_done(cyc, bc, got);
    checks++; if (!got || cyc != 17) begin fails++; $display("FAIL midrst_after_latency: got %0d (done=%b) expected 17", cyc, got); end
    checks++; if (bcd_out !== 20'h00100) begin fails++; $display("FAIL midrst_after_bcd: got %h expected 00100", bcd_out); end
    checks++; if (blank_out !== 5'b11000) begin fails++; $display("FAIL midrst_after_blank: got %b expected 11000", blank_out); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] p;
    logic s; logic [19:0] b; logic [4:0] bl;
    int cyc, bc; bit got;
    for (int n = 0; n < 20; n++) begin
      p = 16'($urandom);
      model(p, s, b, bl);
      start_conv(p);
      wait_done(cyc, bc, got);
      checks++; if (!got || cyc != 17) begin fails++; $display("FAIL rand_latency p=%h: got %0d (done=%b) expected 17", p, cyc, got); end
      checks++; if (sign_out !== s) begin fails++; $display("FAIL rand_sign p=%h: got %b expected %b", p, sign_out, s); end
      checks++; if (bcd_out !== b) begin fails++; $display("FAIL rand_bcd p=%h: got %h expected %h", p, bcd_out, b); end
      checks++; if (blank_out !== bl) begin fails++; $display("FAIL rand_blank p=%h: got %b expected %b", p, blank_out, bl); end
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    product = '0;
    test_reset();
    test_known_values();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
